// File: rtl/bank_htu_req_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bank_htu_req_sched                                         |
// | Description : Arbitrates core and maintenance requests to one cache bank |
// |               and sequences tag lookup, write-back, fill and commit.     |
// |               Optional BANK_HTU_SCHED_PERF_EN adds hit/miss counters.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bank_htu_req_sched #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         core_req_valid_i,
  output logic         core_req_ready_o,
  input  logic         core_req_write_i,
  input  logic [31:10] core_req_tag_i,
  input  logic         core_req_offset_i,
  input  logic         mnt_req_valid_i,
  output logic         mnt_req_ready_o,
  input  logic         mnt_req_flush_i,
  input  logic [31:10] mnt_req_tag_i,
  input  logic         mnt_req_offset_i,
  output logic         htu_op_read_o,
  output logic         htu_op_write_o,
  output logic         htu_op_flush_o,
  output logic         htu_op_invalidate_o,
  output logic         htu_set_hit_WV_o,
  output logic         htu_access_offset_o,
  output logic [31:10] htu_access_tag_o,
  input  logic         htu_cacheline_hit_i,
  input  logic         htu_need_evit_WV_i,
  input  logic [31:10] htu_evit_tag_i,
  input  logic [2:0]   htu_access_way_i,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic         mem_req_write_o,
  output logic [31:10] mem_req_tag_o,
  input  logic         mem_resp_valid_i,
  output logic         done_valid_o,
  output logic         done_hit_o,
  output logic [2:0]   done_way_o
`ifdef BANK_HTU_SCHED_PERF_EN
  ,
  output logic [15:0]  perf_hit_cnt_o,
  output logic [15:0]  perf_miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WB_REQ    = 3'd2,
    WB_WAIT   = 3'd3,
    FILL_REQ  = 3'd4,
    FILL_WAIT = 3'd5,
    COMMIT    = 3'd6
  } state_t;

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  state_t         r_state;
  state_t         w_next_state;
  logic [3:0]     r_starve_cnt;
  logic           r_is_mnt;      // 0: core op, 1: maintenance op
  logic           r_kind;        // core: write; maintenance: flush
  logic [31:10]   r_tag;
  logic           r_offset;
  logic [31:10]   r_wb_tag;
  logic           r_hit;
  logic           r_fmiss_done;

  logic           w_idle;
  logic           w_active;
  logic           w_commit;
  logic           w_grant_mnt;
  logic           w_grant_core;
  logic           w_core_hs;
  logic           w_mnt_hs;

  assign w_idle       = (r_state == IDLE);
  assign w_active     = ~w_idle;
  assign w_commit     = (r_state == COMMIT);
  // Maintenance has priority until the core has been passed over STARVE_LIMIT times
  assign w_grant_mnt  = mnt_req_valid_i &
                        ~(core_req_valid_i & (r_starve_cnt >= c_starve_limit));
  assign w_grant_core = core_req_valid_i & ~w_grant_mnt;
  assign w_core_hs    = rst_i & w_idle & w_grant_core;
  assign w_mnt_hs     = rst_i & w_idle & w_grant_mnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state        = r_state;
    core_req_ready_o    = w_core_hs;
    mnt_req_ready_o     = w_mnt_hs;
    htu_op_read_o       = w_active & ~r_is_mnt & ~r_kind;
    htu_op_write_o      = w_active & ~r_is_mnt &  r_kind;
    htu_op_flush_o      = w_active &  r_is_mnt &  r_kind;
    htu_op_invalidate_o = w_active &  r_is_mnt & ~r_kind;
    htu_set_hit_WV_o    = w_commit;
    htu_access_tag_o    = w_active ? r_tag : '0;
    htu_access_offset_o = w_active & r_offset;
    mem_req_valid_o     = 1'b0;
    mem_req_write_o     = 1'b0;
    mem_req_tag_o       = '0;
    done_valid_o        = w_commit | r_fmiss_done;
    done_hit_o          = w_commit & r_hit;
    done_way_o          = w_commit ? htu_access_way_i : 3'd0;

    case (r_state)
      IDLE: begin
        if (w_core_hs || w_mnt_hs) w_next_state = LOOKUP;
      end
      LOOKUP: begin
        if (r_is_mnt) begin
          if (!r_kind)                  w_next_state = COMMIT;
          else if (htu_cacheline_hit_i) w_next_state = WB_REQ;
          else                          w_next_state = IDLE;
        end else if (htu_cacheline_hit_i) begin
          w_next_state = COMMIT;
        end else if (htu_need_evit_WV_i) begin
          w_next_state = WB_REQ;
        end else begin
          w_next_state = FILL_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_write_o = 1'b1;
        mem_req_tag_o   = r_wb_tag;
        if (mem_req_ready_i) w_next_state = WB_WAIT;
      end
      WB_WAIT: begin
        // Only a flush reaches write-back from a maintenance op; it needs no fill
        if (mem_resp_valid_i) w_next_state = r_is_mnt ? COMMIT : FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_tag_o   = r_tag;
        if (mem_req_ready_i) w_next_state = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_resp_valid_i) w_next_state = COMMIT;
      end
      COMMIT: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve_cnt <= 4'd0;
      r_is_mnt     <= 1'b0;
      r_kind       <= 1'b0;
      r_tag        <= '0;
      r_offset     <= 1'b0;
      r_wb_tag     <= '0;
      r_hit        <= 1'b0;
      r_fmiss_done <= 1'b0;
    end else begin
      r_fmiss_done <= 1'b0;

      if (!core_req_valid_i || w_core_hs) begin
        r_starve_cnt <= 4'd0;
      end else if (w_mnt_hs && r_starve_cnt != 4'hF) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_core_hs) begin
        r_is_mnt <= 1'b0;
        r_kind   <= core_req_write_i;
        r_tag    <= core_req_tag_i;
        r_offset <= core_req_offset_i;
      end else if (w_mnt_hs) begin
        r_is_mnt <= 1'b1;
        r_kind   <= mnt_req_flush_i;
        r_tag    <= mnt_req_tag_i;
        r_offset <= mnt_req_offset_i;
      end

      if (r_state == LOOKUP) begin
        r_hit        <= htu_cacheline_hit_i;
        r_wb_tag     <= r_is_mnt ? r_tag : htu_evit_tag_i;
        r_fmiss_done <= r_is_mnt & r_kind & ~htu_cacheline_hit_i;
      end
    end
  end

`ifdef BANK_HTU_SCHED_PERF_EN
  logic [15:0] r_perf_hit_cnt;
  logic [15:0] r_perf_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_perf_hit_cnt  <= 16'd0;
      r_perf_miss_cnt <= 16'd0;
    end else if (w_commit && !r_is_mnt) begin
      if (r_hit) begin
        if (r_perf_hit_cnt != 16'hFFFF) r_perf_hit_cnt <= r_perf_hit_cnt + 16'd1;
      end else begin
        if (r_perf_miss_cnt != 16'hFFFF) r_perf_miss_cnt <= r_perf_miss_cnt + 16'd1;
      end
    end
  end

  assign perf_hit_cnt_o  = r_perf_hit_cnt;
  assign perf_miss_cnt_o = r_perf_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_htu_req_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bank_htu_req_sched                                      |
// | Description : Directed self-checking bench for bank_htu_req_sched.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_bank_htu_req_sched;

  localparam int STARVE_LIMIT = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         core_req_valid_i = 1'b0, core_req_write_i = 1'b0, core_req_offset_i = 1'b0;
  logic [31:10] core_req_tag_i = '0;
  logic         mnt_req_valid_i = 1'b0, mnt_req_flush_i = 1'b0, mnt_req_offset_i = 1'b0;
  logic [31:10] mnt_req_tag_i = '0;
  logic         htu_cacheline_hit_i = 1'b0, htu_need_evit_WV_i = 1'b0;
  logic [31:10] htu_evit_tag_i = '0;
  logic [2:0]   htu_access_way_i = '0;
  logic         mem_req_ready_i = 1'b0, mem_resp_valid_i = 1'b0;
  logic         core_req_ready_o, mnt_req_ready_o;
  logic         htu_op_read_o, htu_op_write_o, htu_op_flush_o, htu_op_invalidate_o;
  logic         htu_set_hit_WV_o, htu_access_offset_o;
  logic [31:10] htu_access_tag_o;
  logic         mem_req_valid_o, mem_req_write_o;
  logic [31:10] mem_req_tag_o;
  logic         done_valid_o, done_hit_o;
  logic [2:0]   done_way_o;
`ifdef BANK_HTU_SCHED_PERF_EN
  logic [15:0]  perf_hit_cnt_o, perf_miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  bank_htu_req_sched #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_write_i(core_req_write_i), .core_req_tag_i(core_req_tag_i),
    .core_req_offset_i(core_req_offset_i),
    .mnt_req_valid_i(mnt_req_valid_i), .mnt_req_ready_o(mnt_req_ready_o),
    .mnt_req_flush_i(mnt_req_flush_i), .mnt_req_tag_i(mnt_req_tag_i),
    .mnt_req_offset_i(mnt_req_offset_i),
    .htu_op_read_o(htu_op_read_o), .htu_op_write_o(htu_op_write_o),
    .htu_op_flush_o(htu_op_flush_o), .htu_op_invalidate_o(htu_op_invalidate_o),
    .htu_set_hit_WV_o(htu_set_hit_WV_o), .htu_access_offset_o(htu_access_offset_o),
    .htu_access_tag_o(htu_access_tag_o),
    .htu_cacheline_hit_i(htu_cacheline_hit_i), .htu_need_evit_WV_i(htu_need_evit_WV_i),
    .htu_evit_tag_i(htu_evit_tag_i), .htu_access_way_i(htu_access_way_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_write_o(mem_req_write_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .done_valid_o(done_valid_o), .done_hit_o(done_hit_o), .done_way_o(done_way_o)
`ifdef BANK_HTU_SCHED_PERF_EN
    , .perf_hit_cnt_o(perf_hit_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, written by the model
  logic         e_crdy, e_mrdy, e_rd, e_wr, e_fl, e_inv, e_set, e_off;
  logic         e_mv, e_mw, e_dv, e_dh;
  logic [31:10] e_tag, e_mtag;
  logic [2:0]   e_dw;
  bit           model_on = 1'b0;
  int           m_starve;
  bit           m_fm_done;

  task automatic clr_exp();
    e_crdy = 0; e_mrdy = 0; e_rd = 0; e_wr = 0; e_fl = 0; e_inv = 0; e_set = 0;
    e_off = 0; e_mv = 0; e_mw = 0; e_dv = 0; e_dh = 0; e_tag = '0; e_mtag = '0; e_dw = '0;
  endtask

  task automatic next_cycle(output bit aborted);
    if (!core_req_valid_i) m_starve = 0;
    @(posedge clk_i); #3;
    clr_exp();
    aborted = !rst_i;
  endtask

  task automatic set_op(input bit is_mnt, input bit kind, input logic [31:10] tag, input bit off);
    e_rd  = !is_mnt && !kind;
    e_wr  = !is_mnt &&  kind;
    e_fl  =  is_mnt &&  kind;
    e_inv =  is_mnt && !kind;
    e_tag = tag;
    e_off = off;
  endtask

  // One transaction from the lookup cycle on; returns early when reset strikes
  task automatic run_txn(input bit is_mnt, input bit kind, input logic [31:10] tag, input bit off);
    bit ab, hit, do_wb, do_fill, do_commit, seen;
    logic [31:10] wbtag;
    set_op(is_mnt, kind, tag, off);
    hit = htu_cacheline_hit_i;
    do_wb = 0; do_fill = 0; do_commit = 1; wbtag = '0;
    if (is_mnt && kind) begin
      if (hit) begin do_wb = 1; wbtag = tag; end
      else begin do_commit = 0; m_fm_done = 1; end
    end else if (!is_mnt && !hit) begin
      do_fill = 1;
      if (htu_need_evit_WV_i) begin do_wb = 1; wbtag = htu_evit_tag_i; end
    end
    next_cycle(ab); if (ab) return;
    if (do_wb) begin
      do begin
        set_op(is_mnt, kind, tag, off); e_mv = 1; e_mw = 1; e_mtag = wbtag;
        seen = mem_req_ready_i; next_cycle(ab); if (ab) return;
      end while (!seen);
      do begin
        set_op(is_mnt, kind, tag, off);
        seen = mem_resp_valid_i; next_cycle(ab); if (ab) return;
      end while (!seen);
    end
    if (do_fill) begin
      do begin
        set_op(is_mnt, kind, tag, off); e_mv = 1; e_mw = 0; e_mtag = tag;
        seen = mem_req_ready_i; next_cycle(ab); if (ab) return;
      end while (!seen);
      do begin
        set_op(is_mnt, kind, tag, off);
        seen = mem_resp_valid_i; next_cycle(ab); if (ab) return;
      end while (!seen);
    end
    if (do_commit) begin
      set_op(is_mnt, kind, tag, off);
      e_set = 1; e_dv = 1; e_dh = hit; e_dw = htu_access_way_i;
      next_cycle(ab);
    end
  endtask

  initial begin : model
    bit ab, g_c, g_m, is_mnt, kind, off;
    logic [31:10] tag;
    m_starve = 0; m_fm_done = 0;
    @(posedge clk_i); #3;
    clr_exp();
    model_on = 1'b1;
    forever begin
      if (!rst_i) begin
        m_starve = 0; m_fm_done = 0;
        next_cycle(ab);
      end else begin
        e_dv = m_fm_done; m_fm_done = 0;
        g_m = mnt_req_valid_i && !(core_req_valid_i && m_starve >= STARVE_LIMIT);
        g_c = core_req_valid_i && !g_m;
        e_mrdy = g_m; e_crdy = g_c;
        if (g_c) m_starve = 0;
        else if (g_m && core_req_valid_i) m_starve++;
        is_mnt = g_m;
        kind   = g_m ? mnt_req_flush_i  : core_req_write_i;
        tag    = g_m ? mnt_req_tag_i    : core_req_tag_i;
        off    = g_m ? mnt_req_offset_i : core_req_offset_i;
        next_cycle(ab);
        if (!ab && (g_c || g_m)) run_txn(is_mnt, kind, tag, off);
      end
    end
  end

  always @(negedge clk_i) begin
    if (model_on) begin
      chk("core_ready", core_req_ready_o, e_crdy);
      chk("mnt_ready", mnt_req_ready_o, e_mrdy);
      chk("op_rd_wr_fl_inv", {htu_op_read_o, htu_op_write_o, htu_op_flush_o, htu_op_invalidate_o},
          {e_rd, e_wr, e_fl, e_inv});
      chk("set_hit", htu_set_hit_WV_o, e_set);
      chk("access_tag_off", {htu_access_tag_o, htu_access_offset_o}, {e_tag, e_off});
      chk("mem_req", {mem_req_valid_o, mem_req_write_o, mem_req_tag_o}, {e_mv, e_mw, e_mtag});
      chk("done", {done_valid_o, done_hit_o, done_way_o}, {e_dv, e_dh, e_dw});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  initial begin : stim
    int stall;
    int n;
    bit g [0:15];
    #1 rst_i = 1'b0;
    @(posedge clk_i); #2;
    core_req_valid_i = 1; mnt_req_valid_i = 1;
    @(negedge clk_i);
    chk("reset_ready", {core_req_ready_o, mnt_req_ready_o, done_valid_o, mem_req_valid_o}, 0);
    cyc(2);
    core_req_valid_i = 0; mnt_req_valid_i = 0; rst_i = 1'b1;
    cyc(2);

    // core read hit
    core_req_valid_i = 1; core_req_write_i = 0; core_req_tag_i = 22'h1234; core_req_offset_i = 1;
    cyc(1);
    core_req_valid_i = 0; htu_cacheline_hit_i = 1; htu_access_way_i = 3'd5;
    cyc(1);
    htu_cacheline_hit_i = 0;
    @(negedge clk_i);
    chk("rdhit_done_valid", done_valid_o, 1);
    chk("rdhit_done_hit", done_hit_o, 1);
    chk("rdhit_done_way", done_way_o, 3'd5);
    chk("rdhit_no_mem", mem_req_valid_o, 0);
    cyc(2);

    // core write miss, dirty victim, memory stalls three cycles
    core_req_valid_i = 1; core_req_write_i = 1; core_req_tag_i = 22'h2222; core_req_offset_i = 0;
    cyc(1);
    core_req_valid_i = 0; htu_need_evit_WV_i = 1; htu_evit_tag_i = 22'h00AB;
    cyc(1);
    htu_need_evit_WV_i = 0; htu_evit_tag_i = '0; mem_resp_valid_i = 1;
    stall = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (mem_req_valid_o && mem_req_write_o && mem_req_tag_o == 22'h00AB) stall++;
      cyc(1);
      mem_resp_valid_i = 0;
    end
    chk("wb_stall_cycles", stall, 3);
    mem_req_ready_i = 1;
    cyc(1);
    mem_req_ready_i = 0;
    cyc(1);
    mem_resp_valid_i = 1;
    cyc(1);
    mem_resp_valid_i = 0; mem_req_ready_i = 1;
    @(negedge clk_i);
    chk("fill_req", {mem_req_valid_o, mem_req_write_o, mem_req_tag_o}, {2'b10, 22'h2222});
    cyc(1);
    mem_req_ready_i = 0; mem_resp_valid_i = 1;
    cyc(1);
    mem_resp_valid_i = 0;
    @(negedge clk_i);
    chk("wmiss_set_hit", htu_set_hit_WV_o, 1);
    chk("wmiss_done_hit", {done_valid_o, done_hit_o}, 2'b10);
    cyc(2);

    // flush miss
    mnt_req_valid_i = 1; mnt_req_flush_i = 1; mnt_req_tag_i = 22'h3333; mnt_req_offset_i = 1;
    cyc(1);
    mnt_req_valid_i = 0;
    cyc(1);
    @(negedge clk_i);
    chk("fmiss_done", {done_valid_o, done_hit_o, htu_set_hit_WV_o}, 3'b100);
    cyc(2);

    // flush hit: write-back of the access tag
    mnt_req_valid_i = 1; mnt_req_flush_i = 1; mnt_req_tag_i = 22'h0F0F; mnt_req_offset_i = 0;
    cyc(1);
    mnt_req_valid_i = 0; htu_cacheline_hit_i = 1;
    cyc(1);
    htu_cacheline_hit_i = 0; mem_req_ready_i = 1;
    @(negedge clk_i);
    chk("fhit_wb_req", {mem_req_valid_o, mem_req_write_o, mem_req_tag_o}, {2'b11, 22'h0F0F});
    cyc(1);
    mem_req_ready_i = 0; mem_resp_valid_i = 1;
    cyc(1);
    mem_resp_valid_i = 0;
    @(negedge clk_i);
    chk("fhit_done_hit", {done_valid_o, done_hit_o}, 2'b11);
    cyc(2);

    // invalidate hit: commit with no memory traffic
    mnt_req_valid_i = 1; mnt_req_flush_i = 0; mnt_req_tag_i = 22'h0055; mnt_req_offset_i = 1;
    cyc(1);
    mnt_req_valid_i = 0; htu_cacheline_hit_i = 1; htu_access_way_i = 3'd2;
    cyc(1);
    htu_cacheline_hit_i = 0;
    @(negedge clk_i);
    chk("inv_no_mem", mem_req_valid_o, 0);
    chk("inv_done", {done_valid_o, done_hit_o, done_way_o}, {2'b11, 3'd2});
    cyc(2);

    // core read miss, clean victim
    core_req_valid_i = 1; core_req_write_i = 0; core_req_tag_i = 22'h3FFFFF; core_req_offset_i = 0;
    cyc(1);
    core_req_valid_i = 0;
    cyc(2);
    mem_req_ready_i = 1;
    cyc(1);
    mem_req_ready_i = 0;
    cyc(1);
    mem_resp_valid_i = 1;
    cyc(1);
    mem_resp_valid_i = 0;
    cyc(2);

    // both requesters continuously valid
    htu_cacheline_hit_i = 1; htu_access_way_i = 3'd1;
    core_req_valid_i = 1; core_req_write_i = 0; core_req_tag_i = 22'h0111;
    mnt_req_valid_i = 1; mnt_req_flush_i = 0; mnt_req_tag_i = 22'h0222;
    n = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (n < 16 && mnt_req_ready_o && mnt_req_valid_i) begin g[n] = 1'b1; n++; end
      else if (n < 16 && core_req_ready_o && core_req_valid_i) begin g[n] = 1'b0; n++; end
      @(posedge clk_i); #2;
    end
    core_req_valid_i = 0; mnt_req_valid_i = 0; htu_cacheline_hit_i = 0;
    chk("starve_ngrants", n, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_grant%0d_is_mnt", i), g[i], (i % 5) != 4);
    cyc(3);

    // reset dropped while waiting for fill data
    core_req_valid_i = 1; core_req_write_i = 0; core_req_tag_i = 22'h0ABC; core_req_offset_i = 1;
    cyc(1);
    core_req_valid_i = 0;
    cyc(1);
    mem_req_ready_i = 1;
    cyc(1);
    mem_req_ready_i = 0; rst_i = 1'b0;
    #1;
    chk("rst_async_outs", {htu_op_read_o, htu_access_tag_o, htu_access_offset_o, mem_req_valid_o, done_valid_o}, 0);
    mem_resp_valid_i = 1;
    cyc(2);
    rst_i = 1'b1;
    cyc(2);
    mem_resp_valid_i = 0;
    @(negedge clk_i);
    chk("stray_resp_idle", {htu_op_read_o, done_valid_o, mem_req_valid_o}, 0);
    cyc(1);
    core_req_valid_i = 1; core_req_tag_i = 22'h0777; core_req_offset_i = 0;
    cyc(1);
    core_req_valid_i = 0; htu_cacheline_hit_i = 1; htu_access_way_i = 3'd3;
    cyc(1);
    htu_cacheline_hit_i = 0;
    @(negedge clk_i);
    chk("post_rst_done", {done_valid_o, done_hit_o, done_way_o}, {2'b11, 3'd3});
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_htu_req_sched.md
BANK_HTU_REQ_SCHED -- requirements
Module: bank_htu_req_sched

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive maintenance grants allowed while a core request waits (range 1..15).
REQ-002 SHALL have port: clk_i, in, 1, single clock; all state on rising edge.
REQ-003 SHALL have port: rst_i, in, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports: core_req_valid_i in 1 / core_req_ready_o out 1, core request handshake.
REQ-005 SHALL have ports: core_req_write_i in 1 (1=write, 0=read), core_req_tag_i in [31:10], core_req_offset_i in 1.
REQ-006 SHALL have ports: mnt_req_valid_i in 1 / mnt_req_ready_o out 1, maintenance request handshake.
REQ-007 SHALL have ports: mnt_req_flush_i in 1 (1=flush, 0=invalidate), mnt_req_tag_i in [31:10], mnt_req_offset_i in 1.
REQ-008 SHALL have ports: htu_op_read_o, htu_op_write_o, htu_op_flush_o, htu_op_invalidate_o, htu_set_hit_WV_o, htu_access_offset_o, all out 1; htu_access_tag_o out [31:10]; these drive the set-entry tag unit.
REQ-009 SHALL have ports: htu_cacheline_hit_i in 1, htu_need_evit_WV_i in 1, htu_evit_tag_i in [31:10], htu_access_way_i in [2:0].
REQ-010 SHALL have ports: mem_req_valid_o out 1, mem_req_ready_i in 1, mem_req_write_o out 1, mem_req_tag_o out [31:10], mem_resp_valid_i in 1.
REQ-011 SHALL have ports: done_valid_o out 1, done_hit_o out 1, done_way_o out [2:0].

Function
REQ-012 SHALL implement FSM states IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, COMMIT.
REQ-013 Ready outputs SHALL be asserted only in IDLE, at most one of them high per cycle, selected by the arbiter.
REQ-014 Arbiter: maintenance wins when both are valid, except that after STARVE_LIMIT consecutive maintenance grants with a core request pending, the next grant goes to the core; the counter clears on any core grant or when the core is not valid.
REQ-015 On handshake, op, tag and offset SHALL be latched; IDLE->LOOKUP.
REQ-016 In LOOKUP, COMMIT and all memory states, exactly one htu_op_* output SHALL be high, matching the latched op; htu_access_tag_o/offset_o SHALL be the latched values; all htu_op_* SHALL be 0 in IDLE.
REQ-017 htu_set_hit_WV_o SHALL be high only in COMMIT, for exactly one cycle.
REQ-018 LOOKUP transitions: read/write hit -> COMMIT; read/write miss with htu_need_evit_WV_i=1 -> WB_REQ (latch htu_evit_tag_i); read/write miss, clean -> FILL_REQ; flush hit -> WB_REQ (latched access tag); flush miss -> IDLE with done pulse, hit=0; invalidate -> COMMIT.
REQ-019 WB_REQ: mem_req_valid_o=1, write=1, tag=eviction tag; held stable until mem_req_ready_i; then -> WB_WAIT.
REQ-020 WB_WAIT: on mem_resp_valid_i, flush -> COMMIT, else -> FILL_REQ.
REQ-021 FILL_REQ: mem_req_valid_o=1, write=0, tag=access tag until ready -> FILL_WAIT; on mem_resp_valid_i -> COMMIT.
REQ-022 mem_resp_valid_i outside the WAIT states SHALL be ignored; mem_req_valid_o SHALL be 0 outside the REQ states.
REQ-023 COMMIT SHALL pulse done_valid_o for one cycle with done_hit_o = hit result latched in LOOKUP and done_way_o = htu_access_way_i; next state is IDLE.
REQ-024 Hit latency: handshake at edge N -> done_valid_o high in cycle N+2 -> ready possible again at N+3.

Reset
REQ-025 While rst_i=0: state IDLE, starvation counter 0, all outputs 0, except that ready is permitted only after reset release.
REQ-026 Reset asserted mid-operation SHALL abandon the transaction immediately; no done pulse; mem_req_valid_o drops asynchronously.

Configuration
REQ-027 With BANK_HTU_SCHED_PERF_EN defined: extra outputs perf_hit_cnt_o [15:0] and perf_miss_cnt_o [15:0], incremented in COMMIT for core ops, saturating at 16'hFFFF, reset to 0. Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Verification
REQ-028 Core read hit, tag 22'h1234: done_valid_o in cycle N+2, done_hit_o=1, done_way_o=hit way; no mem_req.
REQ-029 Core write miss with dirty victim tag 22'h00AB, mem_req_ready_i delayed 3 cycles: write req with tag 22'h00AB held 3 cycles, then read req with the access tag; htu_set_hit_WV_o 1 cycle after fill response.
REQ-030 Maintenance and core both continuously valid, STARVE_LIMIT=4: grant pattern 4 maintenance, then 1 core, repeating.
REQ-031 Flush miss: done pulse in cycle N+2, done_hit_o=0, htu_set_hit_WV_o never high; invalidate hit: COMMIT with no memory traffic.
REQ-032 rst_i dropped in FILL_WAIT: all outputs 0 immediately; after release, a new request completes normally; stray mem_resp_valid_i in IDLE causes no transition.
